axi4_ram_bridge: RTL and testbench



---
 rtl/axi4_ram_bridge_if.sv | 56 +++++
 rtl/axi4_ram_bridge.sv | 185 ++++++++++++++++++
 tb/tb_axi4_ram_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_ram_bridge_if.sv
// AXI4 slave-port bundle (AW/W/B/AR/R) between the SoC memory port and axi4_ram_bridge.
interface axi4_ram_bridge_if #(
    parameter int ID_WIDTH = 4
);
    logic                aw_valid;
    logic                aw_ready;
    logic [ID_WIDTH-1:0] aw_id;
    logic [63:0]         aw_addr;
    logic [7:0]          aw_len;
    logic [1:0]          aw_burst;

    logic                w_valid;
    logic                w_ready;
    logic [63:0]         w_data;
    logic [7:0]          w_strb;
    logic                w_last;

    logic                b_valid;
    logic                b_ready;
    logic [ID_WIDTH-1:0] b_id;
    logic [1:0]          b_resp;

    logic                ar_valid;
    logic                ar_ready;
    logic [ID_WIDTH-1:0] ar_id;
    logic [63:0]         ar_addr;
    logic [7:0]          ar_len;
    logic [1:0]          ar_burst;

    logic                r_valid;
    logic                r_ready;
    logic [ID_WIDTH-1:0] r_id;
    logic [63:0]         r_data;
    logic [1:0]          r_resp;
    logic                r_last;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_burst,
        output w_valid, w_data, w_strb, w_last,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_burst,
        output r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp,
        input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_burst,
        input  w_valid, w_data, w_strb, w_last,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_burst,
        input  r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp,
        output ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );
endinterface

// File: rtl/axi4_ram_bridge.sv
// AXI4 burst slave to 64-bit word-indexed RAM model, one transaction at a time.
// Define AXI4_RAM_BRIDGE_RDATA_REG_EN to register RAM read data (read issued one cycle before r_valid).
module axi4_ram_bridge #(
    parameter int          ID_WIDTH  = 4,
    parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
    parameter logic [63:0] MEM_BYTES = 64'h1000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    axi4_ram_bridge_if.slave  axi,
    output logic              ram_en,
    output logic [63:0]       ram_rIdx,
    input  logic [63:0]       ram_rdata,
    output logic [63:0]       ram_wIdx,
    output logic [63:0]       ram_wdata,
    output logic [63:0]       ram_wmask,
    output logic              ram_wen
);
    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t              state, state_nx;
    logic [63:0]         addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [1:0]          burst_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                err_q;
    logic                prio_rd_q;

    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic in_range, last_beat;
    logic [63:0] idx;

    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [60:0] word;
        logic [60:0] mask;
        word = addr[63:3];
        mask = {53'd0, len};
        if (burst == 2'd0)
            return addr;
        // WRAP only for power-of-two lengths; any other length degrades to INCR
        if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return {(word & ~mask) | ((word + 61'd1) & mask), addr[2:0]};
        return addr + 64'd8;
    endfunction

    function automatic logic [63:0] expand_strb(input logic [7:0] strb);
        logic [63:0] m;
        for (int i = 0; i < 8; i++)
            m[i*8 +: 8] = {8{strb[i]}};
        return m;
    endfunction

    assign ar_hs     = axi.ar_valid && axi.ar_ready;
    assign aw_hs     = axi.aw_valid && axi.aw_ready;
    assign w_hs      = axi.w_valid && axi.w_ready;
    assign r_hs      = axi.r_valid && axi.r_ready;
    assign b_hs      = axi.b_valid && axi.b_ready;
    assign idx       = (addr_q - MEM_BASE) >> 3;
    assign in_range  = (addr_q >= MEM_BASE) && (addr_q < MEM_BASE + MEM_BYTES);
    assign last_beat = (cnt_q == len_q);

`ifdef AXI4_RAM_BRIDGE_RDATA_REG_EN
    logic        rd_have_q;
    logic [63:0] rdata_q;
    logic [1:0]  rresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_have_q <= 1'b0;
        else if (ar_hs || r_hs)
            rd_have_q <= 1'b0;
        else if (state == RD)
            rd_have_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (state == RD && !rd_have_q) begin
            rdata_q <= in_range ? ram_rdata : 64'd0;
            rresp_q <= in_range ? 2'd0 : 2'd2;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            prio_rd_q <= 1'b1;
        end else begin
            if (axi.ar_valid && axi.aw_valid && (ar_hs || aw_hs))
                prio_rd_q <= !prio_rd_q;
            if (aw_hs || b_hs)
                err_q <= 1'b0;
            else if (w_hs && (!in_range || (axi.w_last != last_beat)))
                err_q <= 1'b1;
        end
    end

    // Burst bookkeeping is only consumed after a handshake has loaded it
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            id_q <= axi.ar_id; addr_q <= axi.ar_addr; len_q <= axi.ar_len;
            burst_q <= axi.ar_burst; cnt_q <= 8'd0;
        end else if (aw_hs) begin
            id_q <= axi.aw_id; addr_q <= axi.aw_addr; len_q <= axi.aw_len;
            burst_q <= axi.aw_burst; cnt_q <= 8'd0;
        end else if (r_hs || w_hs) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr(addr_q, len_q, burst_q);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ar_hs) state_nx = RD; else if (aw_hs) state_nx = WR;
            RD:      if (r_hs && last_beat) state_nx = IDLE;
            WR:      if (w_hs && last_beat) state_nx = WRESP;
            WRESP:   if (b_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
        axi.b_valid  = 1'b0; axi.b_id = '0; axi.b_resp = 2'd0;
        axi.r_valid  = 1'b0; axi.r_id = '0; axi.r_data = 64'd0; axi.r_resp = 2'd0; axi.r_last = 1'b0;
        ram_en = 1'b0; ram_wen = 1'b0; ram_rIdx = 64'd0;
        ram_wIdx = 64'd0; ram_wdata = 64'd0; ram_wmask = 64'd0;
        case (state)
            IDLE: begin
                // rst_n gate keeps readies low while reset is held
                axi.ar_ready = rst_n && (!axi.aw_valid || prio_rd_q);
                axi.aw_ready = rst_n && (!axi.ar_valid || !prio_rd_q);
            end
            RD: begin
                ram_rIdx   = idx;
                axi.r_id   = id_q;
`ifdef AXI4_RAM_BRIDGE_RDATA_REG_EN
                if (!rd_have_q) begin
                    ram_en = in_range;
                end else begin
                    axi.r_valid = 1'b1;
                    axi.r_data  = rdata_q;
                    axi.r_resp  = rresp_q;
                    axi.r_last  = last_beat;
                end
`else
                axi.r_valid = 1'b1;
                axi.r_last  = last_beat;
                if (in_range) begin
                    ram_en     = 1'b1;
                    axi.r_data = ram_rdata;
                end else begin
                    axi.r_resp = 2'd2;
                end
`endif
            end
            WR: begin
                axi.w_ready = 1'b1;
                if (axi.w_valid && in_range) begin
                    ram_en    = 1'b1;
                    ram_wen   = 1'b1;
                    ram_wIdx  = idx;
                    ram_wdata = axi.w_data;
                    ram_wmask = expand_strb(axi.w_strb);
                end
            end
            WRESP: begin
                axi.b_valid = 1'b1;
                axi.b_id    = id_q;
                axi.b_resp  = err_q ? 2'd2 : 2'd0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi4_ram_bridge.sv
// Scoreboard bench for axi4_ram_bridge: directed AXI traffic, queued expectations, negedge monitors.
`timescale 1ns/1ps
module tb_axi4_ram_bridge;
    localparam int IDW = 4;
`ifdef AXI4_RAM_BRIDGE_RDATA_REG_EN
    localparam int RLAT    = 2;
    localparam bit EN_PRES = 1'b0;
`else
    localparam int RLAT    = 1;
    localparam bit EN_PRES = 1'b1;
`endif

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0]    data;
        logic [1:0]     resp;
        logic           last;
        logic [63:0]    ridx;
        logic           chk_idx;
        logic           en;
    } r_exp_t;
    typedef struct { logic [63:0] idx; logic [63:0] data; logic [63:0] mask; } w_exp_t;
    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ram_en, ram_wen;
    logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

    r_exp_t exp_r[$];
    w_exp_t exp_w[$];
    b_exp_t exp_b[$];
    bit     exp_g[$];
    bit     chk_grant = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;
    r_exp_t er;
    w_exp_t ew;
    b_exp_t eb;
    bit     eg;

    axi4_ram_bridge_if #(.ID_WIDTH(IDW)) bus();

    axi4_ram_bridge #(.ID_WIDTH(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .axi       (bus),
        .ram_en    (ram_en),
        .ram_rIdx  (ram_rIdx),
        .ram_rdata (ram_rdata),
        .ram_wIdx  (ram_wIdx),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_wen   (ram_wen)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_word(input logic [63:0] i);
        return {~i[31:0], i[31:0]};
    endfunction

    assign ram_rdata = ram_word(ram_rIdx);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s actual=event required=none t=%0t", name, $time);
    endtask

    task automatic push_r(input logic [IDW-1:0] id, input logic [63:0] data, input logic [1:0] resp,
                          input logic last, input logic [63:0] ridx, input logic ci, input logic en);
        r_exp_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        e.ridx = ridx; e.chk_idx = ci; e.en = en;
        exp_r.push_back(e);
    endtask

    task automatic push_w(input logic [63:0] i, input logic [63:0] d, input logic [63:0] m);
        w_exp_t e;
        e.idx = i; e.data = d; e.mask = m;
        exp_w.push_back(e);
    endtask

    task automatic push_b(input logic [IDW-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        exp_b.push_back(e);
    endtask

    task automatic do_ar(input logic [IDW-1:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst;
        bus.ar_valid = 1'b1;
        @(negedge clk);
        while (!bus.ar_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.ar_ready) note_fail("ar_timeout");
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic do_aw(input logic [IDW-1:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst;
        bus.aw_valid = 1'b1;
        @(negedge clk);
        while (!bus.aw_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.aw_ready) note_fail("aw_timeout");
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        bus.w_data = data; bus.w_strb = strb; bus.w_last = last;
        bus.w_valid = 1'b1;
        @(negedge clk);
        while (!bus.w_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.w_ready) note_fail("w_timeout");
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_r.size() + exp_w.size() + exp_b.size()) != 0 && n < 300) begin
            @(negedge clk); n++;
        end
        if ((exp_r.size() + exp_w.size() + exp_b.size()) != 0) begin
            note_fail("drain_timeout");
            exp_r.delete(); exp_w.delete(); exp_b.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitors: compare whenever the DUT completes a handshake or drives a RAM write
    always @(negedge clk) begin
        if (bus.r_valid && bus.r_ready) begin
            if (exp_r.size() == 0) note_fail("r_unexpected");
            else begin
                er = exp_r.pop_front();
                chk("r_id", 64'(bus.r_id), 64'(er.id));
                chk("r_data", bus.r_data, er.data);
                chk("r_resp", 64'(bus.r_resp), 64'(er.resp));
                chk("r_last", 64'(bus.r_last), 64'(er.last));
                chk("r_ram_en", 64'(ram_en), 64'(er.en));
                if (er.chk_idx) chk("ram_rIdx", ram_rIdx, er.ridx);
            end
        end
        if (ram_wen) begin
            if (exp_w.size() == 0) note_fail("ram_wen_unexpected");
            else begin
                ew = exp_w.pop_front();
                chk("ram_wIdx", ram_wIdx, ew.idx);
                chk("ram_wdata", ram_wdata, ew.data);
                chk("ram_wmask", ram_wmask, ew.mask);
                chk("w_ram_en", 64'(ram_en), 64'd1);
            end
        end
        if (bus.b_valid && bus.b_ready) begin
            if (exp_b.size() == 0) note_fail("b_unexpected");
            else begin
                eb = exp_b.pop_front();
                chk("b_id", 64'(bus.b_id), 64'(eb.id));
                chk("b_resp", 64'(bus.b_resp), 64'(eb.resp));
            end
        end
        if (chk_grant && ((bus.ar_valid && bus.ar_ready) || (bus.aw_valid && bus.aw_ready))) begin
            if (exp_g.size() == 0) note_fail("grant_unexpected");
            else begin
                eg = exp_g.pop_front();
                chk("grant_is_read", 64'(bus.ar_valid && bus.ar_ready), 64'(eg));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int wseq[4];
        wseq = '{3, 0, 1, 2};
        bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_burst = '0;
        bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
        bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_burst = '0;
        bus.r_ready = 1; bus.b_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_wen", 64'(ram_wen), 64'd0);
        chk("rst_r_data", bus.r_data, 64'd0);

        // Arbitration: both channels requesting out of reset, read owns priority first
        exp_g = '{1, 0, 1, 0, 1, 0, 1, 0};
        chk_grant = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    push_r(IDW'(i), ram_word(64'(i)), 2'd0, 1'b1, 64'(i), 1'b1, EN_PRES);
                    do_ar(IDW'(i), 64'h8000_0000 + 64'(i) * 8, 8'd0, 2'd1);
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    push_w(64'h10 + 64'(i), 64'hC0DE_0000_0000_0000 + 64'(i), 64'hFFFF_FFFF_FFFF_FFFF);
                    push_b(IDW'(8 + i), 2'd0);
                    do_aw(IDW'(8 + i), 64'h8000_0080 + 64'(i) * 8, 8'd0, 2'd1);
                    do_w(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, 1'b1);
                end
            end
            begin
                @(negedge clk);
                chk("rst_ar_ready_req", 64'(bus.ar_ready), 64'd0);
                chk("rst_aw_ready_req", 64'(bus.aw_ready), 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        wait_drain();
        chk_grant = 1'b0;
        chk("grant_rounds_left", 64'(exp_g.size()), 64'd0);

        // Single read with latency check
        push_r(4'd3, 64'hFFFF_FFFD_0000_0002, 2'd0, 1'b1, 64'd2, 1'b1, EN_PRES);
        do_ar(4'd3, 64'h8000_0010, 8'd0, 2'd1);
        n = 0;
        while (!bus.r_valid && n < 10) begin @(negedge clk); n++; end
        if (n == 0) begin @(negedge clk); n = 1; end
        chk("rd_latency", 64'(n), 64'(RLAT));
        wait_drain();

        // INCR write, low-word strobes
        for (int i = 0; i < 4; i++)
            push_w(64'(i), 64'hA000_0000_0000_0000 + 64'(i), 64'h0000_0000_FFFF_FFFF);
        push_b(4'd5, 2'd0);
        do_aw(4'd5, 64'h8000_0000, 8'd3, 2'd1);
        for (int i = 0; i < 4; i++)
            do_w(64'hA000_0000_0000_0000 + 64'(i), 8'h0F, i == 3);
        wait_drain();

        // WRAP read 3,0,1,2
        for (int k = 0; k < 4; k++)
            push_r(4'd2, ram_word(64'(wseq[k])), 2'd0, k == 3, 64'(wseq[k]), 1'b1, EN_PRES);
        do_ar(4'd2, 64'h8000_0018, 8'd3, 2'd2);
        wait_drain();

        // FIXED read stays on one word
        for (int k = 0; k < 3; k++)
            push_r(4'd6, 64'hFFFF_FFFB_0000_0004, 2'd0, k == 2, 64'd4, 1'b1, EN_PRES);
        do_ar(4'd6, 64'h8000_0020, 8'd2, 2'd0);
        wait_drain();

        // Decode window edges
        push_r(4'd1, 64'd0, 2'd2, 1'b1, 64'd0, 1'b0, 1'b0);
        do_ar(4'd1, 64'h7FFF_FFF8, 8'd0, 2'd1);
        wait_drain();
        push_r(4'd7, 64'hFE00_0000_01FF_FFFF, 2'd0, 1'b1, 64'h01FF_FFFF, 1'b1, EN_PRES);
        do_ar(4'd7, 64'h8FFF_FFF8, 8'd0, 2'd1);
        wait_drain();
        push_r(4'd8, 64'd0, 2'd2, 1'b1, 64'd0, 1'b0, 1'b0);
        do_ar(4'd8, 64'h9000_0000, 8'd0, 2'd1);
        wait_drain();

        // Early w_last: data still written, response SLVERR
        push_w(64'h40, 64'h1111_2222_3333_4444, 64'hFF00_FF00_00FF_00FF);
        push_w(64'h41, 64'h5555_6666_7777_8888, 64'hFF00_FF00_00FF_00FF);
        push_b(4'd6, 2'd2);
        do_aw(4'd6, 64'h8000_0200, 8'd1, 2'd1);
        do_w(64'h1111_2222_3333_4444, 8'hA5, 1'b1);
        do_w(64'h5555_6666_7777_8888, 8'hA5, 1'b1);
        wait_drain();

        // Out-of-window write: no RAM write, SLVERR
        push_b(4'd7, 2'd2);
        do_aw(4'd7, 64'h9000_0000, 8'd0, 2'd1);
        do_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
        wait_drain();

        // R backpressure: outputs frozen while r_ready is low
        bus.r_ready = 1'b0;
        push_r(4'd4, 64'hFFFF_FFF7_0000_0008, 2'd0, 1'b0, 64'd8, 1'b1, EN_PRES);
        push_r(4'd4, 64'hFFFF_FFF6_0000_0009, 2'd0, 1'b1, 64'd9, 1'b1, EN_PRES);
        do_ar(4'd4, 64'h8000_0040, 8'd1, 2'd1);
        n = 0;
        while (!bus.r_valid && n < 10) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_r_valid", 64'(bus.r_valid), 64'd1);
            chk("stall_r_data", bus.r_data, 64'hFFFF_FFF7_0000_0008);
            chk("stall_ram_rIdx", ram_rIdx, 64'd8);
        end
        @(posedge clk); #1;
        bus.r_ready = 1'b1;
        wait_drain();

        // Reset during an 8-beat write after four beats
        for (int i = 0; i < 4; i++)
            push_w(64'h20 + 64'(i), 64'hBEEF_0000_0000_0000 + 64'(i), 64'hFFFF_FFFF_FFFF_FFFF);
        do_aw(4'd9, 64'h8000_0100, 8'd7, 2'd1);
        for (int i = 0; i < 4; i++)
            do_w(64'hBEEF_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
        bus.w_data = 64'hBEEF_0000_0000_0004; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
        bus.w_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("midrst_ram_wen", 64'(ram_wen), 64'd0);
        chk("midrst_ram_en", 64'(ram_en), 64'd0);
        chk("midrst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("midrst_beats_seen", 64'(exp_w.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.w_valid = 1'b0;
        rst_n = 1'b1;
        push_w(64'd1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        push_b(4'd10, 2'd0);
        do_aw(4'd10, 64'h8000_0008, 8'd0, 2'd1);
        do_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
